// File: rtl/pool2d.sv
// pool2d: generalised 2-D max/average pooling with optional fused ReLU.
// Walks every window one element per clock and writes one result per window.
module pool2d #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 8,
   parameter int IN_SIZE    = 28,
   parameter int POOL       = 2,
   parameter int STRIDE     = 2,
   localparam int OUT_SIZE  = (IN_SIZE - POOL) / STRIDE + 1
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic mode,
   input  logic relu_en,
   input  logic [CHANNELS*IN_SIZE*IN_SIZE*DATA_WIDTH-1:0]   in_feature_flat,
   output logic [CHANNELS*OUT_SIZE*OUT_SIZE*DATA_WIDTH-1:0] out_feature_flat,
   output logic busy,
   output logic done
);

   localparam int IN_TOTAL  = CHANNELS * IN_SIZE * IN_SIZE;
   localparam int OUT_TOTAL = CHANNELS * OUT_SIZE * OUT_SIZE;
   localparam int AW  = DATA_WIDTH + $clog2(POOL * POOL);
   localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int OW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int PW  = (POOL > 1) ? $clog2(POOL) : 1;
   localparam int IIW = (IN_TOTAL > 1) ? $clog2(IN_TOTAL) : 1;
   localparam int OIW = (OUT_TOTAL > 1) ? $clog2(OUT_TOTAL) : 1;
   // One extra bit keeps the divisor positive as a signed operand.
   localparam logic signed [AW:0] DIV = (AW + 1)'(POOL * POOL);

   typedef enum logic [1:0] {IDLE, ACC, WRITE, FINISH} state_t;

   state_t state_q, state_d;
   logic [CHW-1:0] ch_q, ch_d;
   logic [OW-1:0]  r_q, r_d, q_q, q_d;
   logic [PW-1:0]  kr_q, kr_d, kc_q, kc_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic mode_q, mode_d, relu_q, relu_d, done_q, done_d;

   logic signed [DATA_WIDTH-1:0] in_mem [IN_TOTAL];
   logic signed [DATA_WIDTH-1:0] out_q  [OUT_TOTAL];

   logic [IIW-1:0] in_idx;
   logic [OIW-1:0] wr_idx;
   logic signed [DATA_WIDTH-1:0] elem;
   logic signed [AW-1:0] elem_ext;
   logic signed [AW:0]   quot;
   logic signed [DATA_WIDTH-1:0] wr_data;
   logic wr_en;

   genvar g;
   generate
      for (g = 0; g < IN_TOTAL; g++) begin : g_in
         assign in_mem[g] = in_feature_flat[g*DATA_WIDTH +: DATA_WIDTH];
      end
      for (g = 0; g < OUT_TOTAL; g++) begin : g_out
         assign out_feature_flat[g*DATA_WIDTH +: DATA_WIDTH] = out_q[g];
      end
   endgenerate

   assign in_idx = IIW'((int'(ch_q) * IN_SIZE
                       + int'(r_q) * STRIDE + int'(kr_q)) * IN_SIZE
                       + int'(q_q) * STRIDE + int'(kc_q));
   assign wr_idx = OIW'((int'(ch_q) * OUT_SIZE + int'(r_q)) * OUT_SIZE
                       + int'(q_q));
   assign elem     = in_mem[in_idx];
   assign elem_ext = AW'(elem);
   assign quot     = (AW + 1)'(acc_q) / DIV;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

   // Pooled result for the current window, with optional ReLU clamp.
   always_comb begin
      wr_data = mode_q ? DATA_WIDTH'(quot) : DATA_WIDTH'(acc_q);
      if (relu_q && wr_data < 0) wr_data = '0;
   end

   // Next-state logic: window walk, accumulation and output stepping.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      r_d     = r_q;
      q_d     = q_q;
      kr_d    = kr_q;
      kc_d    = kc_q;
      acc_d   = acc_q;
      mode_d  = mode_q;
      relu_d  = relu_q;
      done_d  = done_q;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (start) begin
               ch_d    = '0;
               r_d     = '0;
               q_d     = '0;
               kr_d    = '0;
               kc_d    = '0;
               acc_d   = '0;
               mode_d  = mode;
               relu_d  = relu_en;
               state_d = ACC;
            end
         end
         ACC: begin
            if (kr_q == '0 && kc_q == '0)
               acc_d = elem_ext;
            else if (!mode_q)
               acc_d = (elem_ext > acc_q) ? elem_ext : acc_q;
            else
               acc_d = acc_q + elem_ext;
            if (kc_q == PW'(POOL - 1)) begin
               kc_d = '0;
               if (kr_q == PW'(POOL - 1)) begin
                  kr_d    = '0;
                  state_d = WRITE;
               end else begin
                  kr_d = kr_q + 1'b1;
               end
            end else begin
               kc_d = kc_q + 1'b1;
            end
         end
         WRITE: begin
            wr_en   = 1'b1;
            state_d = ACC;
            if (q_q == OW'(OUT_SIZE - 1)) begin
               q_d = '0;
               if (r_q == OW'(OUT_SIZE - 1)) begin
                  r_d = '0;
                  if (ch_q == CHW'(CHANNELS - 1)) begin
                     ch_d    = '0;
                     state_d = FINISH;
                  end else begin
                     ch_d = ch_q + 1'b1;
                  end
               end else begin
                  r_d = r_q + 1'b1;
               end
            end else begin
               q_d = q_q + 1'b1;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and the output array; reset aborts any pass.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q    <= '0;
         r_q     <= '0;
         q_q     <= '0;
         kr_q    <= '0;
         kc_q    <= '0;
         acc_q   <= '0;
         mode_q  <= 1'b0;
         relu_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < OUT_TOTAL; i++) out_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         r_q     <= r_d;
         q_q     <= q_d;
         kr_q    <= kr_d;
         kc_q    <= kc_d;
         acc_q   <= acc_d;
         mode_q  <= mode_d;
         relu_q  <= relu_d;
         done_q  <= done_d;
         if (wr_en) out_q[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_pool2d.sv
// tb_pool2d: directed checks of pool2d in four configurations
// (2x2/2 single channel, 3x3/1 overlap, 2-channel timing, 1x1 copy).
module tb_pool2d;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mode = 1'b0;
   logic relu = 1'b0;
   logic [3:0] st = '0;
   logic [3:0] dn;

   logic [255:0] in_a = '0;
   logic [511:0] in3 = '0;
   logic [63:0]  in4 = '0;
   logic [63:0]  o1, o2, o4;
   logic [127:0] o3;
   logic busy1, busy2, busy3, busy4;
   logic done1, done2, done3, done4;

   int n_cmp = 0;
   int n_bad = 0;

   assign dn = {done4, done3, done2, done1};

   always #5 clk = ~clk;

   pool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(4), .POOL(2), .STRIDE(2)) u1 (
      .clk(clk), .reset(reset), .start(st[0]), .mode(mode), .relu_en(relu),
      .in_feature_flat(in_a), .out_feature_flat(o1), .busy(busy1), .done(done1));

   pool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(4), .POOL(3), .STRIDE(1)) u2 (
      .clk(clk), .reset(reset), .start(st[1]), .mode(mode), .relu_en(relu),
      .in_feature_flat(in_a), .out_feature_flat(o2), .busy(busy2), .done(done2));

   pool2d #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(2)) u3 (
      .clk(clk), .reset(reset), .start(st[2]), .mode(mode), .relu_en(relu),
      .in_feature_flat(in3), .out_feature_flat(o3), .busy(busy3), .done(done3));

   pool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(2), .POOL(1), .STRIDE(1)) u4 (
      .clk(clk), .reset(reset), .start(st[3]), .mode(mode), .relu_en(relu),
      .in_feature_flat(in4), .out_feature_flat(o4), .busy(busy4), .done(done4));

   // Pulse start on unit u (sampled at E0); n = edges after E0 until done seen.
   task automatic run(input int u, output int n);
      @(negedge clk);
      st[u] = 1'b1;
      @(posedge clk);
      #1;
      st[u] = 1'b0;
      n = 0;
      while (dn[u] !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({busy1, busy2, busy3, busy4} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_busy got %b want 0000", {busy1, busy2, busy3, busy4});
      end
      n_cmp++;
      if (dn !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_done got %b want 0000", dn);
      end
      n_cmp++;
      if (o1 !== '0 || o2 !== '0 || o3 !== '0 || o4 !== '0) begin
         n_bad++;
         $display("FAIL reset_out got %h %h %h %h want 0", o1, o2, o3, o4);
      end
   endtask

   task automatic test_max();
      int n;
      int e[4];
      e = '{5, 7, 13, 15};
      for (int i = 0; i < 16; i++) in_a[i*16 +: 16] = 16'(i);
      mode = 1'b0;
      relu = 1'b0;
      run(0, n);
      n_cmp++;
      if (n !== 21) begin
         n_bad++;
         $display("FAIL max_latency got %0d want 21", n);
      end
      n_cmp++;
      if (busy1 !== 1'b0) begin
         n_bad++;
         $display("FAIL max_busy_at_done got %b want 0", busy1);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (o1[i*16 +: 16] !== 16'(e[i])) begin
            n_bad++;
            $display("FAIL max[%0d] got %0d want %0d", i, $signed(o1[i*16 +: 16]), e[i]);
         end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (done1 !== 1'b0) begin
         n_bad++;
         $display("FAIL max_done_once got %b want 0", done1);
      end
   endtask

   task automatic test_avg();
      int n;
      int e[4];
      e = '{2, 4, 10, 12};
      for (int i = 0; i < 16; i++) in_a[i*16 +: 16] = 16'(i);
      mode = 1'b1;
      relu = 1'b0;
      run(0, n);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (o1[i*16 +: 16] !== 16'(e[i])) begin
            n_bad++;
            $display("FAIL avg[%0d] got %0d want %0d", i, $signed(o1[i*16 +: 16]), e[i]);
         end
      end
      in_a[0*16 +: 16] = -16'sd1;
      in_a[1*16 +: 16] = -16'sd2;
      in_a[4*16 +: 16] = -16'sd3;
      in_a[5*16 +: 16] = -16'sd4;
      run(0, n);
      n_cmp++;
      if (o1[15:0] !== 16'hFFFE) begin
         n_bad++;
         $display("FAIL avg_trunc got %0d want -2", $signed(o1[15:0]));
      end
   endtask

   task automatic test_relu();
      int n;
      for (int i = 0; i < 16; i++) in_a[i*16 +: 16] = -16'sd5;
      mode = 1'b0;
      relu = 1'b1;
      run(0, n);
      n_cmp++;
      if (o1 !== 64'h0) begin
         n_bad++;
         $display("FAIL relu_on got %h want 0", o1);
      end
      relu = 1'b0;
      run(0, n);
      n_cmp++;
      if (o1 !== {4{16'hFFFB}}) begin
         n_bad++;
         $display("FAIL relu_off got %h want fffbfffbfffbfffb", o1);
      end
      in_a = '0;
      in_a[0*16 +: 16] = 16'h8000;
      in_a[1*16 +: 16] = 16'h7FFF;
      in_a[5*16 +: 16] = 16'h0001;
      in_a[10*16 +: 16] = 16'h8000;
      in_a[11*16 +: 16] = 16'h8000;
      in_a[14*16 +: 16] = 16'h8000;
      in_a[15*16 +: 16] = 16'h8000;
      mode = 1'b1;
      run(0, n);
      n_cmp++;
      if (o1 !== {16'h8000, 16'h0, 16'h0, 16'h0}) begin
         n_bad++;
         $display("FAIL avg_extremes got %h want 8000000000000000", o1);
      end
   endtask

   task automatic test_overlap();
      int n;
      int emax[4];
      int eavg[4];
      emax = '{10, 11, 14, 15};
      eavg = '{5, 6, 9, 10};
      for (int i = 0; i < 16; i++) in_a[i*16 +: 16] = 16'(i);
      mode = 1'b0;
      relu = 1'b0;
      run(1, n);
      n_cmp++;
      if (n !== 41) begin
         n_bad++;
         $display("FAIL ovl_latency got %0d want 41", n);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (o2[i*16 +: 16] !== 16'(emax[i])) begin
            n_bad++;
            $display("FAIL ovl_max[%0d] got %0d want %0d", i, $signed(o2[i*16 +: 16]), emax[i]);
         end
      end
      mode = 1'b1;
      run(1, n);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (o2[i*16 +: 16] !== 16'(eavg[i])) begin
            n_bad++;
            $display("FAIL ovl_avg[%0d] got %0d want %0d", i, $signed(o2[i*16 +: 16]), eavg[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int first_k;
      int second_k;
      int dn_cnt;
      logic [127:0] emax;
      logic [127:0] eavg;
      first_k = -1;
      second_k = -1;
      dn_cnt = 0;
      for (int i = 0; i < 32; i++) in3[i*16 +: 16] = 16'(i);
      emax = {16'd31, 16'd29, 16'd23, 16'd21, 16'd15, 16'd13, 16'd7, 16'd5};
      eavg = {16'd28, 16'd26, 16'd20, 16'd18, 16'd12, 16'd10, 16'd4, 16'd2};
      mode = 1'b0;
      relu = 1'b0;
      @(negedge clk);
      st[2] = 1'b1;
      @(posedge clk);
      #1;
      st[2] = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         @(posedge clk);
         #1;
         if (done3 === 1'b1) begin
            dn_cnt++;
            if (first_k < 0) first_k = k;
            else if (second_k < 0) second_k = k;
         end
         if (k == 1 || k == 40) begin
            n_cmp++;
            if (busy3 !== 1'b1) begin
               n_bad++;
               $display("FAIL b2b_busy_k%0d got %b want 1", k, busy3);
            end
         end
         if (k == 5) begin
            st[2] = 1'b1;
            mode = 1'b1;
         end
         if (k == 6) st[2] = 1'b0;
         if (k == 41) begin
            n_cmp++;
            if (busy3 !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b_busy_k41 got %b want 0", busy3);
            end
            n_cmp++;
            if (o3 !== emax) begin
               n_bad++;
               $display("FAIL b2b_pass1 got %h want %h", o3, emax);
            end
            st[2] = 1'b1;
         end
         if (k == 42) begin
            st[2] = 1'b0;
            n_cmp++;
            if (busy3 !== 1'b1) begin
               n_bad++;
               $display("FAIL b2b_restart_busy got %b want 1", busy3);
            end
         end
         if (second_k > 0) break;
      end
      n_cmp++;
      if (first_k !== 41) begin
         n_bad++;
         $display("FAIL b2b_done1_edge got %0d want 41", first_k);
      end
      n_cmp++;
      if (second_k !== 83) begin
         n_bad++;
         $display("FAIL b2b_done2_edge got %0d want 83", second_k);
      end
      n_cmp++;
      if (dn_cnt !== 2) begin
         n_bad++;
         $display("FAIL b2b_done_count got %0d want 2", dn_cnt);
      end
      n_cmp++;
      if (o3 !== eavg) begin
         n_bad++;
         $display("FAIL b2b_pass2 got %h want %h", o3, eavg);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int n;
      int dn_cnt;
      logic [127:0] emax;
      emax = {16'd31, 16'd29, 16'd23, 16'd21, 16'd15, 16'd13, 16'd7, 16'd5};
      dn_cnt = 0;
      mode = 1'b1;
      @(negedge clk);
      st[2] = 1'b1;
      @(posedge clk);
      #1;
      st[2] = 1'b0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_cmp++;
      if (busy3 !== 1'b0 || done3 !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_ctl got busy=%b done=%b want 0 0", busy3, done3);
      end
      n_cmp++;
      if (o3 !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_out got %h want 0", o3);
      end
      repeat (50) begin
         @(posedge clk);
         #1;
         if (done3 === 1'b1) dn_cnt++;
      end
      n_cmp++;
      if (dn_cnt !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_no_done got %0d want 0", dn_cnt);
      end
      mode = 1'b0;
      run(2, n);
      n_cmp++;
      if (n !== 41) begin
         n_bad++;
         $display("FAIL rst_mid_rerun_latency got %0d want 41", n);
      end
      n_cmp++;
      if (o3 !== emax) begin
         n_bad++;
         $display("FAIL rst_mid_rerun got %h want %h", o3, emax);
      end
   endtask

   task automatic test_copy();
      int n;
      in4 = {-16'sd1, 16'sd0, -16'sd7, 16'sd3};
      mode = 1'b1;
      relu = 1'b1;
      run(3, n);
      n_cmp++;
      if (n !== 9) begin
         n_bad++;
         $display("FAIL copy_latency got %0d want 9", n);
      end
      n_cmp++;
      if (o4 !== {16'h0, 16'h0, 16'h0, 16'h3}) begin
         n_bad++;
         $display("FAIL copy_relu got %h want 0000000000000003", o4);
      end
      mode = 1'b0;
      relu = 1'b0;
      run(3, n);
      n_cmp++;
      if (o4 !== in4) begin
         n_bad++;
         $display("FAIL copy_plain got %h want ffff0000fff90003", o4);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_max();
      test_avg();
      test_relu();
      test_overlap();
      test_back_to_back();
      test_reset_mid();
      test_copy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pool2d.md
Name: pool2d

Overview:
- Generalised 2-D pooling layer for the CNN datapath. Successor to the fixed 2×2 max-pool stage.
- Adds parametrised window and stride (overlapping windows allowed), a runtime max/average mode select and an optional fused ReLU.
- Reads one window element per clock from the flat input feature array and writes one pooled result per window into the flat output array.
- Sits between a conv layer and the next conv or dense layer, with a start/done handshake.

Parameters:
- DATA_WIDTH, 16: signed sample width.
- CHANNELS, 8: number of feature-map channels.
- IN_SIZE, 28: input height and width (square maps).
- POOL, 2: window height and width; must satisfy 1 ≤ POOL ≤ IN_SIZE.
- STRIDE, 2: window step; must satisfy 1 ≤ STRIDE.
- OUT_SIZE (localparam): (IN_SIZE−POOL)/STRIDE+1. Trailing rows/columns that do not fill a full window are ignored.

Ports:
- clk  in  1: clock.
- reset  in  1: synchronous, active-high reset.
- start  in  1: begin one full pass; sampled only in IDLE.
- mode  in  1: 0 = max, 1 = average; latched at accepted start.
- relu_en  in  1: 1 = clamp negative results to 0; latched at accepted start.
- in_feature_flat  in  DATA_WIDTH signed × CHANNELS*IN_SIZE*IN_SIZE: index (ch*IN_SIZE+row)*IN_SIZE+col. Must stay stable while busy.
- out_feature_flat  out  DATA_WIDTH signed × CHANNELS*OUT_SIZE*OUT_SIZE: index (ch*OUT_SIZE+r)*OUT_SIZE+q.
- busy  out  1: high whenever the state is not IDLE.
- done  out  1: one-cycle pulse at the end of a pass.

Behaviour:
- Reset:
  - state = IDLE; done, busy = 0.
  - All counters (ch, r, q, kr, kc) and the accumulator = 0.
  - Every out_feature_flat entry = 0.
  - Reset mid-pass aborts immediately with the same values; no done pulse is produced.
- States: IDLE, ACC, WRITE, FINISH.
- IDLE:
  - done <= 0.
  - If start is high: clear all counters, latch mode and relu_en, go to ACC.
  - start is ignored in every other state.
- ACC (one cycle per window element):
  - Element = in[ch][r*STRIDE+kr][q*STRIDE+kc].
  - When kr = kc = 0: accumulator <= element (sign-extended in average mode).
  - Otherwise, max mode: acc <= (elem > acc) ? elem : acc, as a signed compare.
  - Otherwise, average mode: acc <= acc + elem.
  - kc increments and wraps at POOL−1, then kr increments.
  - After element (POOL−1, POOL−1), go to WRITE.
- Accumulator width: DATA_WIDTH + clog2(POOL*POOL) bits, signed. Sums never overflow.
- WRITE:
  - Result: in max mode, the accumulator value.
  - Result: in average mode, acc / (POOL*POOL) as signed division truncating toward zero, then narrowed to DATA_WIDTH (always fits).
  - If relu_en is latched and the result is negative, result = 0.
  - out[ch][r][q] <= result.
  - Advance q, then r, then ch; each wraps at OUT_SIZE−1 (ch at CHANNELS−1).
  - On the last (ch, r, q), go to FINISH; otherwise return to ACC with kr = kc = 0.
- FINISH: done <= 1, state <= IDLE.
- Timing:
  - Let start be sampled at edge E0 and N = CHANNELS*OUT_SIZE²*(POOL²+1).
  - Edges E1..EN perform ACC/WRITE; the last WRITE occurs at EN.
  - done is high between E(N+1) and E(N+2). busy falls at E(N+1), the same edge done rises.
- A start asserted in the cycle done is high is accepted (state is IDLE), so passes can run back to back.
- out_feature_flat entries hold their last written value between passes. Each entry is updated only at its own WRITE.
- POOL = 1 with STRIDE = 1 is a copy pass (plus ReLU if enabled).

Test Plan:
- Max mode: CHANNELS=1, IN_SIZE=4, POOL=2, STRIDE=2, input 0..15 row-major → out = {5,7,13,15}; done pulses exactly once, high after edge E21.
- Average mode, same input → out = {2,4,10,12}. A window of {−1,−2,−3,−4} gives −2 (sum −10, truncation toward zero, not −3).
- ReLU: all inputs −5 in max mode with relu_en = 1 → every output 0. With relu_en = 0 → every output −5. Extremes: window {−32768, 32767, 0, 1} in average mode → 0.
- Overlap: IN_SIZE=4, POOL=3, STRIDE=1, input 0..15 → OUT_SIZE = 2, max = {10,11,14,15}, average = {5,6,9,10}.
- Timing: CHANNELS=2, IN_SIZE=4, POOL=2 → N = 40; busy high from E1 to E40; done high only after E41; a second start during the pass is ignored; a start in the done cycle begins a new pass.
- Reset at edge E10 mid-pass → next cycle busy = 0, done = 0, all outputs 0, no done pulse. A following start completes a correct pass.
